// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Instruction-memory request/response bus between the fetch
//             stage (master) and a variable-latency instruction memory
//             (slave).
//  Signals  : IMemReq_o  - request, driven by fetch
//             IMemAddr_o - request address, driven by fetch
//             IMemRdy_i  - response strobe, driven by memory
//             IMemData_i - fetched word, valid while IMemRdy_i=1
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  IMemReq_o;
    logic [DATA_WIDTH-1:0] IMemAddr_o;
    logic                  IMemRdy_i;
    logic [DATA_WIDTH-1:0] IMemData_i;

    modport master (
        output IMemReq_o,
        output IMemAddr_o,
        input  IMemRdy_i,
        input  IMemData_i
    );

    modport slave (
        input  IMemReq_o,
        input  IMemAddr_o,
        output IMemRdy_i,
        output IMemData_i
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Holds the PC, issues requests to a
//             variable-latency instruction memory and drives the IF/ID
//             register. Accepts redirects (PCSrc_i/PCTarget_i) and
//             stall/flush from the hazard logic.
//             Priority each cycle: reset > PCSrc_i > Flush_i > Stall_i.
//  Ports    : clk_i        in   clock, rising edge
//             rst_n_i      in   asynchronous active-low reset
//             PCSrc_i      in   redirect request
//             PCTarget_i   in   redirect target
//             Stall_i      in   hold IF/ID and PC
//             Flush_i      in   invalidate IF/ID
//             imem         if   instruction-memory bus (master side)
//             Instr_o      out  IF/ID instruction (NOP_INSTR when invalid)
//             PC_o         out  IF/ID PC of Instr_o
//             PCPlus4_o    out  IF/ID PC_o+4
//             InstrValid_o out  Instr_o is a real instruction
//             Misalign_o   out  misaligned redirect seen (sticky)
//  Options  : FETCH_MISALIGN_EN - when defined, a redirect to a target with
//             non-zero low bits raises Misalign_o and parks the unit in HALT
//             until reset. When undefined the low target bits are cleared.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  PCSrc_i,
    input  logic [DATA_WIDTH-1:0] PCTarget_i,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    fetch_unit_if.master          imem,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] PCPlus4_o,
    output logic                  InstrValid_o,
    output logic                  Misalign_o
);

    localparam logic [DATA_WIDTH-1:0] c_PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_ALIGN_MASK = DATA_WIDTH'(3);

`ifdef FETCH_MISALIGN_EN
    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;
`endif

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pending;   // redirect target waiting for DRAIN to finish
    logic [DATA_WIDTH-1:0] r_hold;      // word captured while stalled
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pc_o;
    logic [DATA_WIDTH-1:0] r_pcplus4;
    logic                  r_valid;

    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH-1:0] w_target;

    assign w_xfer   = r_req & imem.IMemRdy_i;
    assign w_pc_inc = r_pc + c_PC_STEP;

`ifdef FETCH_MISALIGN_EN
    logic r_misalign;
    logic w_misaligned;

    assign w_target     = PCTarget_i;
    assign w_misaligned = |(PCTarget_i & c_ALIGN_MASK);
    assign Misalign_o   = r_misalign;
`else
    assign w_target   = PCTarget_i & ~c_ALIGN_MASK;
    assign Misalign_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_pending  <= '0;
            r_hold     <= '0;
            r_req      <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_o     <= RESET_PC;
            r_pcplus4  <= RESET_PC + c_PC_STEP;
            r_valid    <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            r_misalign <= 1'b0;
`endif
        end else
`ifdef FETCH_MISALIGN_EN
        if (r_state == S_HALT) begin
            // Terminal until reset; nothing is requested or delivered.
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (PCSrc_i && w_misaligned) begin
            r_state    <= S_HALT;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_misalign <= 1'b1;
        end else
`endif
        if (PCSrc_i) begin
            // Redirect always kills IF/ID. If a request is outstanding it must
            // be allowed to complete (address held) before the target is used.
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_req   <= 1'b1;
            if ((r_state == S_FETCH || r_state == S_DRAIN) && !w_xfer) begin
                r_pending <= w_target;
                r_state   <= S_DRAIN;
            end else begin
                r_pc    <= w_target;
                r_state <= S_FETCH;
            end
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    if (Flush_i) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                    end
                end

                S_FETCH: begin
                    if (Flush_i) begin
                        // A word arriving alongside a flush is consumed and
                        // dropped, so the PC still moves past it.
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        if (w_xfer) begin
                            r_pc <= w_pc_inc;
                        end
                    end else if (w_xfer) begin
                        if (Stall_i) begin
                            r_hold  <= imem.IMemData_i;
                            r_state <= S_HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_instr   <= imem.IMemData_i;
                            r_pc_o    <= r_pc;
                            r_pcplus4 <= w_pc_inc;
                            r_valid   <= 1'b1;
                            r_pc      <= w_pc_inc;
                        end
                    end else if (!Stall_i) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                    end
                end

                S_HOLD: begin
                    // r_pc still addresses the buffered word.
                    if (Flush_i) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                    end else if (!Stall_i) begin
                        r_instr   <= r_hold;
                        r_pc_o    <= r_pc;
                        r_pcplus4 <= w_pc_inc;
                        r_valid   <= 1'b1;
                        r_pc      <= w_pc_inc;
                        r_state   <= S_FETCH;
                        r_req     <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    r_valid <= 1'b0;
                    r_instr <= NOP_INSTR;
                    if (w_xfer) begin
                        r_pc    <= r_pending;
                        r_state <= S_FETCH;
                    end
                end

                default: begin
                    r_state <= S_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.IMemReq_o  = r_req;
    assign imem.IMemAddr_o = r_pc;   // pc is left untouched during DRAIN, holding the old address
    assign Instr_o         = r_instr;
    assign PC_o            = r_pc_o;
    assign PCPlus4_o       = r_pcplus4;
    assign InstrValid_o    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A wait-state memory model
//             returns ~address as the instruction word; every word the ID
//             stage should accept is queued beforehand and compared when
//             InstrValid_o is seen without Stall_i.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [31:0] c_RESET = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        PCSrc_i = 1'b0;
    logic [31:0] PCTarget_i = '0;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [31:0] Instr_o;
    logic [31:0] PC_o;
    logic [31:0] PCPlus4_o;
    logic        InstrValid_o;
    logic        Misalign_o;

    int   n_checks = 0;
    int   n_err    = 0;
    int   wait_cycles = 0;
    int   wcnt;
    exp_t exp_q[$];

    fetch_unit_if #(.DATA_WIDTH(32)) imem_bus ();

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (c_RESET),
        .NOP_INSTR  (c_NOP)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .PCSrc_i      (PCSrc_i),
        .PCTarget_i   (PCTarget_i),
        .Stall_i      (Stall_i),
        .Flush_i      (Flush_i),
        .imem         (imem_bus),
        .Instr_o      (Instr_o),
        .PC_o         (PC_o),
        .PCPlus4_o    (PCPlus4_o),
        .InstrValid_o (InstrValid_o),
        .Misalign_o   (Misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: answers after wait_cycles idle cycles of a held request.
    assign imem_bus.IMemRdy_i  = imem_bus.IMemReq_o && (wcnt >= wait_cycles);
    assign imem_bus.IMemData_i = ~imem_bus.IMemAddr_o;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            wcnt <= 0;
        else if (!imem_bus.IMemReq_o || imem_bus.IMemRdy_i)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.instr = ~addr;
        e.pc    = addr;
        e.pc4   = addr + 32'd4;
        exp_q.push_back(e);
    endtask

    // ID stage consumes the IF/ID word whenever it is valid and not stalled.
    always @(negedge clk_i) begin
        if (rst_n_i && InstrValid_o && !Stall_i) begin
            exp_t e;
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_instr observed=%h expected=none", Instr_o);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32("sb_instr", Instr_o, e.instr);
                chk32("sb_pc", PC_o, e.pc);
                chk32("sb_pcplus4", PCPlus4_o, e.pc4);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench one delay after an edge with reset just released.
    task automatic do_reset(input int waits);
        rst_n_i     = 1'b0;
        PCSrc_i     = 1'b0;
        Stall_i     = 1'b0;
        Flush_i     = 1'b0;
        PCTarget_i  = '0;
        wait_cycles = waits;
        tick(2);
        chk1 ("rst_req", imem_bus.IMemReq_o, 1'b0);
        chk1 ("rst_valid", InstrValid_o, 1'b0);
        chk32("rst_instr", Instr_o, c_NOP);
        chk32("rst_pc", PC_o, c_RESET);
        chk32("rst_pcplus4", PCPlus4_o, 32'hBFC0_0004);
        chk1 ("rst_misalign", Misalign_o, 1'b0);
        rst_n_i = 1'b1;
    endtask

    task automatic expect_drained(input string tag);
        chk32(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: zero-wait memory, one instruction per cycle
        do_reset(0);
        push_exp(32'hBFC0_0000);
        push_exp(32'hBFC0_0004);
        chk1 ("t1_boot_req", imem_bus.IMemReq_o, 1'b0);
        tick();
        chk1 ("t1_req", imem_bus.IMemReq_o, 1'b1);
        chk32("t1_addr0", imem_bus.IMemAddr_o, 32'hBFC0_0000);
        chk1 ("t1_valid_lo", InstrValid_o, 1'b0);
        tick();
        chk32("t1_addr1", imem_bus.IMemAddr_o, 32'hBFC0_0004);
        chk1 ("t1_valid_hi", InstrValid_o, 1'b1);
        tick();
        chk32("t1_addr2", imem_bus.IMemAddr_o, 32'hBFC0_0008);
        wait_cycles = 100;
        tick(2);
        chk1 ("t1_bubble_valid", InstrValid_o, 1'b0);
        chk32("t1_bubble_instr", Instr_o, c_NOP);
        expect_drained("t1_drained");

        // 2: two wait states
        do_reset(2);
        push_exp(32'hBFC0_0000);
        push_exp(32'hBFC0_0004);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk32("t2_addr_stable", imem_bus.IMemAddr_o, 32'hBFC0_0000);
            chk1 ("t2_req", imem_bus.IMemReq_o, 1'b1);
            chk1 ("t2_wait_valid", InstrValid_o, 1'b0);
            tick();
        end
        chk1 ("t2_valid0", InstrValid_o, 1'b1);
        chk32("t2_pc0", PC_o, 32'hBFC0_0000);
        chk32("t2_addr_next", imem_bus.IMemAddr_o, 32'hBFC0_0004);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk1 ("t2_bubble_valid", InstrValid_o, 1'b0);
            chk32("t2_bubble_instr", Instr_o, c_NOP);
        end
        tick();
        chk1 ("t2_valid1", InstrValid_o, 1'b1);
        chk32("t2_pc1", PC_o, 32'hBFC0_0004);
        wait_cycles = 100;
        tick();
        expect_drained("t2_drained");

        // 3: stall across a transfer, buffered word delivered once
        do_reset(0);
        push_exp(32'hBFC0_0000);
        push_exp(32'hBFC0_0004);
        tick(2);
        Stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1 ("t3_hold_req", imem_bus.IMemReq_o, 1'b0);
            chk32("t3_hold_pc", PC_o, 32'hBFC0_0000);
            chk32("t3_hold_instr", Instr_o, ~32'hBFC0_0000);
            chk1 ("t3_hold_valid", InstrValid_o, 1'b1);
        end
        Stall_i = 1'b0;
        tick();
        chk32("t3_release_pc", PC_o, 32'hBFC0_0004);
        chk32("t3_release_addr", imem_bus.IMemAddr_o, 32'hBFC0_0008);
        chk1 ("t3_release_req", imem_bus.IMemReq_o, 1'b1);
        wait_cycles = 100;
        tick();
        chk1 ("t3_after_valid", InstrValid_o, 1'b0);
        expect_drained("t3_drained");

        // 4: redirect while a request is waiting -> DRAIN
        do_reset(3);
        push_exp(32'hBFC0_0100);
        tick();
        PCSrc_i    = 1'b1;
        PCTarget_i = 32'hBFC0_0100;
        tick();
        PCSrc_i = 1'b0;
        chk1 ("t4_drain_req", imem_bus.IMemReq_o, 1'b1);
        chk32("t4_drain_instr", Instr_o, c_NOP);
        for (int k = 0; k < 3; k++) begin
            chk32("t4_drain_addr", imem_bus.IMemAddr_o, 32'hBFC0_0000);
            chk1 ("t4_drain_valid", InstrValid_o, 1'b0);
            tick();
        end
        chk32("t4_target_addr", imem_bus.IMemAddr_o, 32'hBFC0_0100);
        chk1 ("t4_target_valid", InstrValid_o, 1'b0);
        wait_cycles = 0;
        tick();
        chk32("t4_target_pc", PC_o, 32'hBFC0_0100);
        wait_cycles = 100;
        tick();
        expect_drained("t4_drained");

        // 5: redirect + stall + flush together
        do_reset(0);
        tick(2);
        PCSrc_i    = 1'b1;
        Stall_i    = 1'b1;
        Flush_i    = 1'b1;
        PCTarget_i = 32'hBFC0_0200;
        push_exp(32'hBFC0_0200);
        tick();
        PCSrc_i = 1'b0;
        Stall_i = 1'b0;
        Flush_i = 1'b0;
        chk32("t5_instr_nop", Instr_o, c_NOP);
        chk1 ("t5_valid", InstrValid_o, 1'b0);
        chk32("t5_addr", imem_bus.IMemAddr_o, 32'hBFC0_0200);
        chk1 ("t5_req", imem_bus.IMemReq_o, 1'b1);
        tick();
        wait_cycles = 100;
        tick();
        expect_drained("t5_drained");

        // 6: flush while holding drops the buffered word
        do_reset(0);
        tick(2);
        Stall_i = 1'b1;
        tick();
        Flush_i = 1'b1;
        tick();
        Flush_i = 1'b0;
        Stall_i = 1'b0;
        push_exp(32'hBFC0_0008);
        chk1 ("t6_valid", InstrValid_o, 1'b0);
        chk32("t6_addr", imem_bus.IMemAddr_o, 32'hBFC0_0008);
        chk1 ("t6_req", imem_bus.IMemReq_o, 1'b1);
        tick();
        wait_cycles = 100;
        tick();
        expect_drained("t6_drained");

        // 7: PC wraps past the top of the address space
        do_reset(0);
        tick();
        PCSrc_i    = 1'b1;
        PCTarget_i = 32'hFFFF_FFF8;
        push_exp(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFFC);
        tick();
        PCSrc_i = 1'b0;
        chk32("t7_addr_f8", imem_bus.IMemAddr_o, 32'hFFFF_FFF8);
        chk1 ("t7_valid", InstrValid_o, 1'b0);
        tick(2);
        chk32("t7_pcplus4_wrap", PCPlus4_o, 32'h0000_0000);
        chk32("t7_addr_wrap", imem_bus.IMemAddr_o, 32'h0000_0000);
        wait_cycles = 100;
        tick();
        expect_drained("t7_drained");

        // 8: misaligned redirect target
        do_reset(0);
        tick();
        PCSrc_i    = 1'b1;
        PCTarget_i = 32'hBFC0_0102;
        tick();
        PCSrc_i = 1'b0;
`ifdef FETCH_MISALIGN_EN
        chk1("t8_misalign", Misalign_o, 1'b1);
        chk1("t8_halt_valid", InstrValid_o, 1'b0);
        PCSrc_i    = 1'b1;
        PCTarget_i = 32'hBFC0_0200;
        for (int k = 0; k < 3; k++) begin
            chk1("t8_halt_req", imem_bus.IMemReq_o, 1'b0);
            chk1("t8_halt_misalign", Misalign_o, 1'b1);
            tick();
        end
        PCSrc_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        chk1("t8_reset_misalign", Misalign_o, 1'b0);
        chk1("t8_reset_req", imem_bus.IMemReq_o, 1'b0);
`else
        push_exp(32'hBFC0_0100);
        chk1 ("t8_misalign", Misalign_o, 1'b0);
        chk32("t8_addr_aligned", imem_bus.IMemAddr_o, 32'hBFC0_0100);
        chk1 ("t8_req", imem_bus.IMemReq_o, 1'b1);
        tick();
        chk32("t8_pc", PC_o, 32'hBFC0_0100);
        wait_cycles = 100;
        tick();
`endif
        expect_drained("t8_drained");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
